// File: rtl/find_keypoints.sv
// find_keypoints: octave-1 SIFT scale-space extremum detector over three DoG layers held in 2-cycle-latency BRAMs
//   clk, rst_in (sync, active-high), start (scan pulse)
//   O1L{1,2,3}_read_addr / O1L{1,2,3}_data : layer BRAM read ports, data valid 2 cycles after address
//   O1key_write_addr, O1key_wea, O1_keypoint_out {is_max, y, x} : keypoint BRAM write port
//   keypoints_done (level until next start), O1_DOG_L1L2_done (pulse after last layer read issued)
module find_keypoints #(
  parameter int BIT_DEPTH = 8,
  parameter int DIMENSION = 4,
  localparam int AW = $clog2(DIMENSION*DIMENSION),
  localparam int CW = $clog2(DIMENSION)
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start,
  output logic [AW-1:0]        O1L1_read_addr,
  input  logic [BIT_DEPTH-1:0] O1L1_data,
  output logic [AW-1:0]        O1L2_read_addr,
  input  logic [BIT_DEPTH-1:0] O1L2_data,
  output logic [AW-1:0]        O1L3_read_addr,
  input  logic [BIT_DEPTH-1:0] O1L3_data,
  output logic [AW-1:0]        O1key_write_addr,
  output logic                 O1key_wea,
  output logic [2*CW:0]        O1_keypoint_out,
  output logic                 keypoints_done,
  output logic                 O1_DOG_L1L2_done
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DECIDE, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] ph, ph_n;
  logic [CW-1:0] x, y, x_n, y_n;
  logic [AW-1:0] rd_addr, addr_n, count;
  logic signed [BIT_DEPTH-1:0] c, d1, d2, d3;
  logic is_max, is_min, max_n, min_n, last, wrap, ctr, nb, decide_n;
  logic [1:0] dyp, dxp;
  int row, col;
  assign d1 = $signed(O1L1_data);
  assign d2 = $signed(O1L2_data);
  assign d3 = $signed(O1L3_data);
  assign O1L1_read_addr = rd_addr;
  assign O1L2_read_addr = rd_addr;
  assign O1L3_read_addr = rd_addr;
  // ph counts cycles within one candidate: 0-8 issue, 9-10 drain, 11 decide, 12 next
  always_comb begin
    state_n = state;
    ph_n = ph + 4'd1;
    x_n = x;
    y_n = y;
    last = x == CW'(DIMENSION-2) && y == CW'(DIMENSION-2);
    wrap = x == CW'(DIMENSION-2);
    case (state)
      IDLE, DONE: begin
        ph_n = 4'd0;
        if (start) begin
          state_n = ISSUE;
          x_n = CW'(1);
          y_n = CW'(1);
        end
      end
      ISSUE:  state_n = ph == 4'd8 ? DRAIN : ISSUE;
      DRAIN:  state_n = ph == 4'd10 ? DECIDE : DRAIN;
      DECIDE: state_n = NEXT;
      NEXT: begin
        state_n = last ? DONE : ISSUE;
        ph_n = 4'd0;
        x_n = wrap ? CW'(1) : x + CW'(1);
        y_n = wrap ? y + CW'(1) : y;
      end
      default: state_n = IDLE;
    endcase
    // neighbour offsets +1 so they stay unsigned: centre first, then row-major 3x3 minus centre
    dyp = ph_n == 4'd0 ? 2'd1 : ph_n < 4'd4 ? 2'd0 : ph_n < 4'd6 ? 2'd1 : 2'd2;
    dxp = ph_n == 4'd0 ? 2'd1 :
          (ph_n == 4'd1 || ph_n == 4'd4 || ph_n == 4'd6) ? 2'd0 :
          (ph_n == 4'd2 || ph_n == 4'd7) ? 2'd1 : 2'd2;
    row = int'(y_n) + int'(dyp) - 1;
    col = int'(x_n) + int'(dxp) - 1;
    addr_n = AW'(row * DIMENSION + col);
    // return k lands at ph k+2: ph 2 carries the centre, ph 3..10 the eight neighbours
    ctr = state == ISSUE && ph == 4'd2;
    nb = (state == ISSUE || state == DRAIN) && ph >= 4'd3;
    max_n = ctr ? !(d1 > d2) && !(d3 > d2) : nb ? is_max && d1 < c && d2 < c && d3 < c : is_max;
    min_n = ctr ? !(d1 < d2) && !(d3 < d2) : nb ? is_min && d1 > c && d2 > c && d3 > c : is_min;
    decide_n = state == DRAIN && ph == 4'd10;
  end
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= IDLE;
      ph <= '0;
      x <= '0;
      y <= '0;
      c <= '0;
      is_max <= 1'b0;
      is_min <= 1'b0;
      rd_addr <= '0;
      count <= '0;
      O1key_write_addr <= '0;
      O1key_wea <= 1'b0;
      O1_keypoint_out <= '0;
      keypoints_done <= 1'b0;
      O1_DOG_L1L2_done <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      x <= x_n;
      y <= y_n;
      is_max <= max_n;
      is_min <= min_n;
      if (ctr) c <= d2;
      if (state_n == ISSUE) rd_addr <= addr_n;
      // flags are final once the last neighbour is folded in, so the write is registered on DECIDE entry
      O1key_wea <= decide_n && (max_n || min_n);
      if (decide_n) O1key_write_addr <= count;
      if (decide_n && (max_n || min_n)) O1_keypoint_out <= {max_n, y, x};
      if ((state == IDLE || state == DONE) && start) begin
        count <= '0;
        O1key_write_addr <= '0;
        keypoints_done <= 1'b0;
      end else begin
        if (state == DECIDE && O1key_wea) count <= count + AW'(1);
        if (state == NEXT && last) keypoints_done <= 1'b1;
      end
      O1_DOG_L1L2_done <= state == ISSUE && ph == 4'd8 && last;
    end
  end
endmodule

// File: tb/tb_find_keypoints.sv
// tb_find_keypoints: table-driven directed bench for find_keypoints with 2-cycle BRAM models
module tb_find_keypoints;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic start = 1'b0;
  logic [3:0] a1, a2, a3, waddr;
  logic [7:0] d1, d2, d3, q1, q2, q3;
  logic wea, kd, dog;
  logic [4:0] kout;
  logic [7:0] m1 [16];
  logic [7:0] m2 [16];
  logic [7:0] m3 [16];
  int checks = 0;
  int errors = 0;
  int wa [8];
  logic [4:0] wd [8];
  int nw, np, pc, cycles;
  typedef struct {
    int la; int ia; int va;
    int lb; int ib; int vb;
    int rs; int n;
    logic [4:0] e0; logic [4:0] e1;
  } vec_t;
  vec_t tv [8];
  int exp_addr [9] = '{5, 0, 1, 2, 4, 6, 8, 9, 10};

  find_keypoints dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .O1L1_read_addr(a1), .O1L1_data(d1),
    .O1L2_read_addr(a2), .O1L2_data(d2),
    .O1L3_read_addr(a3), .O1L3_data(d3),
    .O1key_write_addr(waddr), .O1key_wea(wea), .O1_keypoint_out(kout),
    .keypoints_done(kd), .O1_DOG_L1L2_done(dog)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q1 <= m1[a1]; d1 <= q1;
    q2 <= m2[a2]; d2 <= q2;
    q3 <= m3[a3]; d3 <= q3;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a1"}, int'(a1), 0);
    chk({tag, "_a2"}, int'(a2), 0);
    chk({tag, "_a3"}, int'(a3), 0);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_wea"}, int'(wea), 0);
    chk({tag, "_kout"}, int'(kout), 0);
    chk({tag, "_kdone"}, int'(kd), 0);
    chk({tag, "_l1l2"}, int'(dog), 0);
  endtask

  task automatic poke(input int l, input int i, input int v);
    if (l == 1) m1[i] = 8'(v);
    else if (l == 2) m2[i] = 8'(v);
    else if (l == 3) m3[i] = 8'(v);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      m1[i] = 8'd0; m2[i] = 8'd0; m3[i] = 8'd0;
    end
    poke(v.la, v.ia, v.va);
    poke(v.lb, v.ib, v.vb);
  endtask

  task automatic run_scan(input int restart_at, input int exp_n, input logic [4:0] e0, input logic [4:0] e1);
    for (int i = 0; i < 8; i++) begin
      wa[i] = -1; wd[i] = 5'd0;
    end
    nw = 0; np = 0; pc = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    cycles = 0;
    chk("kdone_cleared", int'(kd), 0);
    while (cycles < 200) begin
      if (cycles < 9) begin
        chk("rd_addr_l1", int'(a1), exp_addr[cycles]);
        chk("rd_addr_l2", int'(a2), exp_addr[cycles]);
        chk("rd_addr_l3", int'(a3), exp_addr[cycles]);
      end
      if (cycles == 9) chk("rd_addr_hold", int'(a1), 10);
      if (wea && nw < 8) begin
        wa[nw] = int'(waddr); wd[nw] = kout; nw++;
      end
      if (dog) begin
        np++; pc = cycles;
      end
      if (kd) break;
      start = (cycles == restart_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("done_latency", cycles, 52);
    chk("l1l2_pulses", np, 1);
    chk("l1l2_cycle", pc, 48);
    chk("n_writes", nw, exp_n);
    if (exp_n > 0) begin
      chk("w0_addr", wa[0], 0);
      chk("w0_data", int'(wd[0]), int'(e0));
    end
    if (exp_n > 1) begin
      chk("w1_addr", wa[1], 1);
      chk("w1_data", int'(wd[1]), int'(e1));
    end
    repeat (3) begin
      @(negedge clk);
      chk("kdone_held", int'(kd), 1);
      chk("no_late_write", int'(wea), 0);
    end
  endtask

  initial begin
    tv[0] = '{0, 0, 0,    0, 0, 0,     -1, 0, 5'b00000, 5'b00000};
    tv[1] = '{2, 5, 100,  0, 0, 0,     -1, 1, 5'b10101, 5'b00000};
    tv[2] = '{2, 10, -50, 0, 0, 0,     -1, 1, 5'b01010, 5'b00000};
    tv[3] = '{2, 5, 100,  2, 10, -50,  -1, 2, 5'b10101, 5'b01010};
    tv[4] = '{2, 5, 100,  3, 0, 100,   -1, 0, 5'b00000, 5'b00000};
    tv[5] = '{2, 5, 100,  1, 5, 101,   -1, 0, 5'b00000, 5'b00000};
    tv[6] = '{2, 9, -3,   0, 0, 0,     -1, 1, 5'b01001, 5'b00000};
    tv[7] = '{2, 5, 100,  0, 0, 0,     20, 1, 5'b10101, 5'b00000};
    load(tv[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_in = 1'b0;
    @(negedge clk);
    chk_zero("idle");
    for (int v = 0; v < 8; v++) begin
      load(tv[v]);
      run_scan(tv[v].rs, tv[v].n, tv[v].e0, tv[v].e1);
    end
    load(tv[3]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_reset_wr_addr", int'(waddr), 1);
    rst_in = 1'b1;
    @(negedge clk);
    chk_zero("midscan_reset");
    rst_in = 1'b0;
    run_scan(-1, 2, 5'b10101, 5'b01010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
